hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter LOAD_STALL_CYCLES, default 1: bubble cycles inserted per load-use hazard (legal 1..7).
REQ-002 Parameter MEM_TIMEOUT, default 255: MEMWAIT cycles before mem_err is set (legal 1..65535).
REQ-003 clk  input  1  rising-edge clock; the block has one clock.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 id_rs, id_rt  input  5 each  source registers of the instruction in IF/ID.
REQ-006 id_ex_rs, id_ex_rt  input  5 each  source registers held in ID/EX.
REQ-007 id_ex_memread  input  1  the instruction in ID/EX is a load.
REQ-008 ex_mem_regwrite, ex_mem_rd  input  1, 5  write enable and destination held in EX/MEM.
REQ-009 mem_wb_regwrite, mem_wb_rd  input  1, 5  write enable and destination held in MEM/WB.
REQ-010 ex_mem_memacc  input  1  EX/MEM holds a load or a store.
REQ-011 dmem_ready  input  1  data memory completes the access this cycle.
REQ-012 branch_taken  input  1  EX/MEM branch AND zero.
REQ-013 pc_write, if_id_write  output  1 each  PC and IF/ID load enables.
REQ-014 id_ex_bubble  output  1  zero the ID/EX control fields.
REQ-015 flush_if_id, flush_id_ex, flush_ex_mem  output  1 each  clear the named latch.
REQ-016 pipe_hold  output  1  freeze ID/EX, EX/MEM and MEM/WB.
REQ-017 fwd_a, fwd_b  output  2 each  ALU operand source: 00 register file, 10 EX/MEM alu_result, 01 MEM/WB writeback.
REQ-018 mem_err  output  1  sticky memory-timeout flag.

Function
REQ-019 fwd_a SHALL be combinational: 10 when ex_mem_regwrite is high, ex_mem_rd!=0 and ex_mem_rd==id_ex_rs; otherwise 01 on the same test against MEM/WB; otherwise 00. EX/MEM takes priority over MEM/WB.
REQ-020 fwd_b SHALL follow REQ-019, using id_ex_rt in place of id_ex_rs.
REQ-021 load_use SHALL be id_ex_memread AND id_ex_rt!=0 AND (id_ex_rt==id_rs OR id_ex_rt==id_rt).
REQ-022 The FSM SHALL have three states, RUN, LDSTALL and MEMWAIT, and all control outputs SHALL be combinational from the state and the inputs.
REQ-023 Default outputs SHALL be: pc_write=1, if_id_write=1, all other control outputs 0.
REQ-024 RUN priority SHALL be memory wait, then branch, then load-use.
REQ-025 RUN memory wait: when ex_mem_memacc=1 and dmem_ready=0 -> pipe_hold=1, pc_write=0, if_id_write=0; next state MEMWAIT; wait counter cleared.
REQ-026 RUN branch: when branch_taken=1 and there is no memory wait -> all three flush outputs =1, pc_write=1; next state RUN. Any load_use in the same cycle SHALL be ignored.
REQ-027 RUN load-use: when load_use=1 -> pc_write=0, if_id_write=0, id_ex_bubble=1; stall counter loaded with LOAD_STALL_CYCLES-1; next state LDSTALL if that value is nonzero, else RUN.
REQ-028 LDSTALL SHALL drive the same outputs as REQ-027 and decrement the counter each cycle; it SHALL return to RUN on the cycle the counter is 1.
REQ-029 LDSTALL SHALL still honour a memory wait (REQ-025); the remaining stall count SHALL be preserved and the FSM SHALL resume LDSTALL after MEMWAIT.
REQ-030 MEMWAIT with dmem_ready=0 -> hold outputs as in REQ-025; the 16-bit wait counter increments and saturates.
REQ-031 When the wait counter equals MEM_TIMEOUT, mem_err SHALL set and stay set until rst; the FSM SHALL remain in MEMWAIT.
REQ-032 MEMWAIT with dmem_ready=1 SHALL evaluate exactly as RUN with dmem_ready=1, or as LDSTALL when a stall count is pending.

Reset
REQ-033 rst SHALL force state RUN, both counters 0 and mem_err 0, and SHALL win over all inputs, including in MEMWAIT or LDSTALL mid-operation.
REQ-034 While rst=1, outputs SHALL be at the REQ-023 defaults, with fwd_a and fwd_b still computed combinationally.

Configuration
REQ-035 With HAZ_PERF_EN defined, the block SHALL add outputs stall_cycles[31:0] and flush_count[31:0], both cleared by rst and wrapping at 2^32.
REQ-036 stall_cycles SHALL increment every cycle in which pc_write=0; flush_count SHALL increment every cycle in which flush_if_id=1.
REQ-037 With HAZ_PERF_EN undefined, those ports and their counters SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-038 ex_mem_rd=mem_wb_rd=id_ex_rs=5, both regwrite high -> fwd_a=10; set ex_mem_rd=0 -> fwd_a=01.
REQ-039 id_ex_memread=1, id_ex_rt=id_rs=8, LOAD_STALL_CYCLES=3 -> pc_write=0 for exactly 3 consecutive cycles, then 1.
REQ-040 branch_taken=1 together with load_use=1 -> all three flush outputs =1, pc_write=1 for 1 cycle, no bubble.
REQ-041 ex_mem_memacc=1, dmem_ready low for 4 cycles -> pipe_hold=1 for 4 cycles, deasserted in the cycle dmem_ready=1.
REQ-042 MEM_TIMEOUT=10, dmem_ready held 0 -> mem_err=1 after 10 MEMWAIT cycles; rst pulse -> mem_err=0, state RUN.
REQ-043 HAZ_PERF_EN defined, one 2-cycle stall plus one branch -> stall_cycles=2, flush_count=1.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-side signal bundle for hazard_ctrl; HAZ_PERF_EN adds counter outputs
interface hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_ex_rs;
  logic [4:0]  id_ex_rt;
  logic        id_ex_memread;
  logic        ex_mem_regwrite;
  logic [4:0]  ex_mem_rd;
  logic        mem_wb_regwrite;
  logic [4:0]  mem_wb_rd;
  logic        ex_mem_memacc;
  logic        dmem_ready;
  logic        branch_taken;
  logic        pc_write;
  logic        if_id_write;
  logic        id_ex_bubble;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        flush_ex_mem;
  logic        pipe_hold;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic        mem_err;
`ifdef HAZ_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  modport slave (
    input  id_rs, id_rt, id_ex_rs, id_ex_rt, id_ex_memread,
    input  ex_mem_regwrite, ex_mem_rd, mem_wb_regwrite, mem_wb_rd,
    input  ex_mem_memacc, dmem_ready, branch_taken,
    output pc_write, if_id_write, id_ex_bubble,
    output flush_if_id, flush_id_ex, flush_ex_mem, pipe_hold,
    output fwd_a, fwd_b, mem_err
`ifdef HAZ_PERF_EN
    , output stall_cycles, flush_count
`endif
  );

  modport master (
    output id_rs, id_rt, id_ex_rs, id_ex_rt, id_ex_memread,
    output ex_mem_regwrite, ex_mem_rd, mem_wb_regwrite, mem_wb_rd,
    output ex_mem_memacc, dmem_ready, branch_taken,
    input  pc_write, if_id_write, id_ex_bubble,
    input  flush_if_id, flush_id_ex, flush_ex_mem, pipe_hold,
    input  fwd_a, fwd_b, mem_err
`ifdef HAZ_PERF_EN
    , input stall_cycles, flush_count
`endif
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding, load-use stall, branch flush and memory-wait control; HAZ_PERF_EN adds perf counters
module hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT       = 255
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {RUN, LDSTALL, MEMWAIT} state_t;

  localparam logic [2:0]  STALL_INIT = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [15:0] TIMEOUT    = 16'(MEM_TIMEOUT);

  state_t      state_q, state_d;
  logic [2:0]  stall_q, stall_d;
  logic [15:0] wait_q, wait_d;
  logic        err_q, err_set;

  logic        load_use, mem_wait;
  logic        do_run, do_ld;
  logic        pc_write, if_id_write, bubble, flush, hold;
  logic        pc_write_o, flush_o;

  // Operand source select: a younger producer (EX/MEM) shadows an older one (MEM/WB).
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic ex_we, input logic [4:0] ex_rd,
                                         input logic wb_we, input logic [4:0] wb_rd);
    if (ex_we && ex_rd != 5'd0 && ex_rd == src)      return 2'b10;
    else if (wb_we && wb_rd != 5'd0 && wb_rd == src) return 2'b01;
    else                                             return 2'b00;
  endfunction

  assign hz.fwd_a = fwd_sel(hz.id_ex_rs, hz.ex_mem_regwrite, hz.ex_mem_rd,
                            hz.mem_wb_regwrite, hz.mem_wb_rd);
  assign hz.fwd_b = fwd_sel(hz.id_ex_rt, hz.ex_mem_regwrite, hz.ex_mem_rd,
                            hz.mem_wb_regwrite, hz.mem_wb_rd);

  assign load_use = hz.id_ex_memread && (hz.id_ex_rt != 5'd0) &&
                    ((hz.id_ex_rt == hz.id_rs) || (hz.id_ex_rt == hz.id_rt));
  assign mem_wait = hz.ex_mem_memacc && !hz.dmem_ready;

  // Next-state and control outputs; a ready MEMWAIT reuses the RUN or LDSTALL decision.
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    bubble      = 1'b0;
    flush       = 1'b0;
    hold        = 1'b0;
    state_d     = state_q;
    stall_d     = stall_q;
    wait_d      = wait_q;
    err_set     = 1'b0;
    do_run      = 1'b0;
    do_ld       = 1'b0;

    unique case (state_q)
      RUN:     do_run = 1'b1;
      LDSTALL: do_ld  = 1'b1;
      MEMWAIT: begin
        if (!hz.dmem_ready) begin
          hold        = 1'b1;
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          if (wait_q != 16'hFFFF) wait_d = wait_q + 16'd1;
          if (wait_d == TIMEOUT) err_set = 1'b1;
        end else if (stall_q != 3'd0) begin
          do_ld = 1'b1;
        end else begin
          do_run = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    if ((do_run || do_ld) && mem_wait) begin
      // Remaining stall count is left untouched so LDSTALL resumes afterwards.
      hold        = 1'b1;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      wait_d      = 16'd0;
      state_d     = MEMWAIT;
    end else if (do_run) begin
      if (hz.branch_taken) begin
        flush   = 1'b1;
        state_d = RUN;
      end else if (load_use) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        bubble      = 1'b1;
        stall_d     = STALL_INIT;
        state_d     = (STALL_INIT != 3'd0) ? LDSTALL : RUN;
      end else begin
        state_d = RUN;
      end
    end else if (do_ld) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      bubble      = 1'b1;
      if (stall_q != 3'd0) stall_d = stall_q - 3'd1;
      state_d     = (stall_q <= 3'd1) ? RUN : LDSTALL;
    end
  end

  assign pc_write_o       = rst ? 1'b1 : pc_write;
  assign flush_o          = rst ? 1'b0 : flush;
  assign hz.pc_write      = pc_write_o;
  assign hz.if_id_write   = rst ? 1'b1 : if_id_write;
  assign hz.id_ex_bubble  = rst ? 1'b0 : bubble;
  assign hz.flush_if_id   = flush_o;
  assign hz.flush_id_ex   = flush_o;
  assign hz.flush_ex_mem  = flush_o;
  assign hz.pipe_hold     = rst ? 1'b0 : hold;
  assign hz.mem_err       = err_q & ~rst;

  // State, stall/wait counters and the sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      stall_q <= 3'd0;
      wait_q  <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      wait_q  <= wait_d;
      if (err_set) err_q <= 1'b1;
    end
  end

`ifdef HAZ_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;

  // Free-running event counters; wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (!pc_write_o) stall_cnt <= stall_cnt + 32'd1;
      if (flush_o)     flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign hz.stall_cycles = stall_cnt;
  assign hz.flush_count  = flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed table-driven bench for hazard_ctrl
module tb_hazard_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  hazard_ctrl_if hz();

  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(10)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt;
    logic       memread, exw;
    logic [4:0] exrd;
    logic       wbw;
    logic [4:0] wbrd;
    logic       memacc, ready, br;
    logic [1:0] fa, fb;
    logic       pcw, ifw, bub, fl, hold;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input logic [4:0] id_rs, id_rt, ex_rs, ex_rt,
                              input logic memread, exw, input logic [4:0] exrd,
                              input logic wbw, input logic [4:0] wbrd,
                              input logic memacc, ready, br,
                              input logic [1:0] fa, fb,
                              input logic pcw, ifw, bub, fl, hold);
    vec_t v;
    v.id_rs = id_rs; v.id_rt = id_rt; v.ex_rs = ex_rs; v.ex_rt = ex_rt;
    v.memread = memread; v.exw = exw; v.exrd = exrd; v.wbw = wbw; v.wbrd = wbrd;
    v.memacc = memacc; v.ready = ready; v.br = br;
    v.fa = fa; v.fb = fb; v.pcw = pcw; v.ifw = ifw; v.bub = bub; v.fl = fl; v.hold = hold;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    hz.id_rs = 0; hz.id_rt = 0; hz.id_ex_rs = 0; hz.id_ex_rt = 0;
    hz.id_ex_memread = 0; hz.ex_mem_regwrite = 0; hz.ex_mem_rd = 0;
    hz.mem_wb_regwrite = 0; hz.mem_wb_rd = 0; hz.ex_mem_memacc = 0;
    hz.dmem_ready = 1; hz.branch_taken = 0;
  endtask

  task automatic apply(input vec_t v);
    hz.id_rs = v.id_rs; hz.id_rt = v.id_rt; hz.id_ex_rs = v.ex_rs; hz.id_ex_rt = v.ex_rt;
    hz.id_ex_memread = v.memread; hz.ex_mem_regwrite = v.exw; hz.ex_mem_rd = v.exrd;
    hz.mem_wb_regwrite = v.wbw; hz.mem_wb_rd = v.wbrd; hz.ex_mem_memacc = v.memacc;
    hz.dmem_ready = v.ready; hz.branch_taken = v.br;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_load_use();
    hz.id_ex_memread = 1; hz.id_ex_rt = 5'd8; hz.id_rs = 5'd8;
  endtask

  // {pc_write, id_ex_bubble, pipe_hold}
  function automatic logic [2:0] pbh();
    return {hz.pc_write, hz.id_ex_bubble, hz.pipe_hold};
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    idle();

    //          id_rs id_rt ex_rs ex_rt mr exw exrd wbw wbrd ma rdy br  fa fb pcw ifw bub fl hold
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 1, 0, 0, 0);
    vecs[1]  = mk(0, 0, 5, 0, 0, 1, 5, 1, 5, 0, 1, 0, 2'b10, 2'b00, 1, 1, 0, 0, 0);
    vecs[2]  = mk(0, 0, 5, 0, 0, 1, 0, 1, 5, 0, 1, 0, 2'b01, 2'b00, 1, 1, 0, 0, 0);
    vecs[3]  = mk(0, 0, 3, 7, 0, 1, 3, 1, 7, 0, 1, 0, 2'b10, 2'b01, 1, 1, 0, 0, 0);
    vecs[4]  = mk(0, 0, 4, 4, 0, 0, 4, 1, 4, 0, 1, 0, 2'b01, 2'b01, 1, 1, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 1, 1, 0, 0, 0);
    vecs[6]  = mk(8, 0, 0, 8, 1, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0);
    vecs[7]  = mk(0, 9, 0, 9, 1, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0);
    vecs[8]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 1, 0, 0, 0);
    vecs[9]  = mk(3, 4, 0, 8, 1, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 1, 0, 0, 0);
    vecs[10] = mk(8, 0, 0, 8, 1, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 1, 1, 0, 1, 0);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1);
    vecs[12] = mk(8, 0, 0, 8, 1, 0, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 1);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 1, 1, 0, 0, 0);
    vecs[14] = mk(0, 0, 0, 6, 0, 1, 6, 1, 6, 0, 1, 0, 2'b00, 2'b10, 1, 1, 0, 0, 0);

    // Outputs during reset: defaults, forwarding still live.
    @(negedge clk);
    hz.ex_mem_regwrite = 1; hz.ex_mem_rd = 5'd5; hz.id_ex_rs = 5'd5;
    set_load_use();
    #1;
    chk("rst_ctrl", {hz.pc_write, hz.if_id_write, hz.id_ex_bubble, hz.flush_if_id,
                     hz.flush_id_ex, hz.flush_ex_mem, hz.pipe_hold, hz.mem_err}, 8'b1100_0000);
    chk("rst_fwd_a", hz.fwd_a, 2'b10);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      do_reset();
      apply(vecs[i]);
      #1;
      chk($sformatf("vec%0d_fwd_a", i), hz.fwd_a, vecs[i].fa);
      chk($sformatf("vec%0d_fwd_b", i), hz.fwd_b, vecs[i].fb);
      chk($sformatf("vec%0d_ctrl", i),
          {hz.pc_write, hz.if_id_write, hz.id_ex_bubble, hz.flush_if_id,
           hz.flush_id_ex, hz.flush_ex_mem, hz.pipe_hold},
          {vecs[i].pcw, vecs[i].ifw, vecs[i].bub, vecs[i].fl, vecs[i].fl, vecs[i].fl, vecs[i].hold});
    end

    // Load-use with 3 stall cycles; ID/EX turns into a bubble after the first edge.
    do_reset();
    set_load_use();
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) hz.id_ex_memread = 0;
      #1;
      chk($sformatf("ldstall_pc_c%0d", k), hz.pc_write, (k < 3) ? 1'b1 ^ 1'b1 : 1'b1);
      chk($sformatf("ldstall_bub_c%0d", k), hz.id_ex_bubble, (k < 3) ? 1'b1 : 1'b0);
    end

    // Memory wait for 4 cycles, released in the cycle dmem_ready rises.
    do_reset();
    hz.ex_mem_memacc = 1; hz.dmem_ready = 0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 4) hz.dmem_ready = 1;
      if (k == 5) hz.ex_mem_memacc = 0;
      #1;
      chk($sformatf("memwait_hold_c%0d", k), hz.pipe_hold, (k < 4) ? 1'b1 : 1'b0);
    end

    // Memory wait arriving mid-LDSTALL; the remaining stall resumes afterwards.
    do_reset();
    set_load_use();
    #1 chk("ldmw_c0", pbh(), 3'b010);
    @(negedge clk); hz.id_ex_memread = 0; hz.ex_mem_memacc = 1; hz.dmem_ready = 0;
    #1 chk("ldmw_c1", pbh(), 3'b001);
    @(negedge clk);
    #1 chk("ldmw_c2", pbh(), 3'b001);
    @(negedge clk); hz.dmem_ready = 1;
    #1 chk("ldmw_c3", pbh(), 3'b010);
    @(negedge clk);
    #1 chk("ldmw_c4", pbh(), 3'b010);
    @(negedge clk);
    #1 chk("ldmw_c5", pbh(), 3'b100);

    // Branch with load-use in RUN after a stall finished: flush wins.
    @(negedge clk); set_load_use(); hz.branch_taken = 1;
    #1 chk("br_lu_flush", {hz.flush_if_id, hz.flush_id_ex, hz.flush_ex_mem, hz.pc_write, hz.id_ex_bubble}, 5'b11110);

    // Timeout: mem_err rises after the 10th MEMWAIT cycle and stays.
    do_reset();
    hz.ex_mem_memacc = 1; hz.dmem_ready = 0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      #1 chk($sformatf("tmo_err_e%0d", j), hz.mem_err, (j >= 11) ? 1'b1 : 1'b0);
    end
    chk("tmo_hold", hz.pipe_hold, 1'b1);
    @(negedge clk); hz.dmem_ready = 1;
    #1 chk("tmo_ready_hold", hz.pipe_hold, 1'b0);
    @(negedge clk); hz.dmem_ready = 0;
    #1 chk("tmo_sticky", hz.mem_err, 1'b1);
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    #1 chk("tmo_in_rst", {hz.pc_write, hz.pipe_hold, hz.mem_err}, 3'b100);
    @(negedge clk); rst = 1'b0; idle();
    #1 chk("tmo_after_rst", {hz.pc_write, hz.pipe_hold, hz.mem_err}, 3'b100);
    @(negedge clk);
    #1 chk("tmo_cleared", hz.mem_err, 1'b0);

    // Reset mid-LDSTALL returns straight to RUN.
    do_reset();
    set_load_use();
    @(negedge clk); hz.id_ex_memread = 0;
    #1 chk("rstld_stalled", hz.pc_write, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1 chk("rstld_run", {hz.pc_write, hz.id_ex_bubble}, 2'b10);

`ifdef HAZ_PERF_EN
    // One 3-cycle load stall and one branch flush.
    do_reset();
    #1 chk("perf_zero", {hz.stall_cycles, hz.flush_count} != 64'd0, 1'b0);
    set_load_use();
    @(negedge clk); idle();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); hz.branch_taken = 1;
    @(negedge clk); hz.branch_taken = 0;
    @(negedge clk);
    #1 chk("perf_stall", hz.stall_cycles, 32'd3);
    chk("perf_flush", hz.flush_count, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
